// File: rtl/div_scheduler_if.sv
// Bundle of the requester, divider and response channels around div_scheduler.
// Port names are written from the scheduler's point of view.
interface div_scheduler_if #(
    parameter int WIDTH   = 32,
    parameter int NUM_REQ = 4
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]       req_valid_i;
    logic [NUM_REQ-1:0]       req_ready_o;
    logic [NUM_REQ*WIDTH-1:0] req_dividend_i;
    logic [NUM_REQ*WIDTH-1:0] req_divisor_i;
    logic [NUM_REQ-1:0]       req_signed_i;

    logic                     div_start_o;
    logic [WIDTH-1:0]         div_dividend_o;
    logic [WIDTH-1:0]         div_divisor_o;
    logic [WIDTH-1:0]         div_quotient_i;
    logic [WIDTH-1:0]         div_remainder_i;
    logic                     div_ready_i;

    logic                     rsp_valid_o;
    logic                     rsp_ready_i;
    logic [ID_W-1:0]          rsp_id_o;
    logic [WIDTH-1:0]         rsp_quotient_o;
    logic [WIDTH-1:0]         rsp_remainder_o;

    // Scheduler side.
    modport master (
        input  req_valid_i, req_dividend_i, req_divisor_i, req_signed_i,
        output req_ready_o,
        output div_start_o, div_dividend_o, div_divisor_o,
        input  div_quotient_i, div_remainder_i, div_ready_i,
        output rsp_valid_o, rsp_id_o, rsp_quotient_o, rsp_remainder_o,
        input  rsp_ready_i
    );

    // Requesters, divider and response consumer.
    modport slave (
        output req_valid_i, req_dividend_i, req_divisor_i, req_signed_i,
        input  req_ready_o,
        input  div_start_o, div_dividend_o, div_divisor_o,
        output div_quotient_i, div_remainder_i, div_ready_i,
        input  rsp_valid_o, rsp_id_o, rsp_quotient_o, rsp_remainder_o,
        output rsp_ready_i
    );
endinterface

// File: rtl/div_scheduler.sv
// Round-robin front end sharing one unsigned divider among NUM_REQ requesters,
// adding signed division and a local divide-by-zero bypass.
module div_scheduler #(
    parameter int WIDTH   = 32,
    parameter int NUM_REQ = 4
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    div_scheduler_if.master bus
);
    localparam int ID_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_e;

    state_e           r_state;
    state_e           w_next_state;

    logic [ID_W-1:0]  r_rr_ptr;
    logic [ID_W-1:0]  r_id;
    logic [WIDTH-1:0] r_mag_a;
    logic [WIDTH-1:0] r_mag_b;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_r;
    logic             r_neg_q;
    logic             r_neg_r;

    logic             w_grant_vld;
    logic [ID_W-1:0]  w_grant_id;
    logic [WIDTH-1:0] w_sel_a;
    logic [WIDTH-1:0] w_sel_b;
    logic             w_sel_sgn;
    logic             w_a_neg;
    logic             w_b_neg;
    logic             w_div_zero;

    // Requester index `offset` positions after `base`, wrapping at NUM_REQ.
    function automatic logic [ID_W-1:0] f_wrap(input logic [ID_W-1:0] base, input int offset);
        int v;
        v = (int'(base) + offset) % NUM_REQ;
        return v[ID_W-1:0];
    endfunction

    // Walk offsets from far to near so the nearest valid requester wins.
    // NOTE: every signal written in an always_comb gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_id  = r_rr_ptr;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (bus.req_valid_i[f_wrap(r_rr_ptr, i)]) begin
                w_grant_vld = 1'b1;
                w_grant_id  = f_wrap(r_rr_ptr, i);
            end
        end
    end

    assign w_sel_a    = bus.req_dividend_i[int'(w_grant_id)*WIDTH +: WIDTH];
    assign w_sel_b    = bus.req_divisor_i[int'(w_grant_id)*WIDTH +: WIDTH];
    assign w_sel_sgn  = bus.req_signed_i[w_grant_id];
    assign w_a_neg    = w_sel_sgn & w_sel_a[WIDTH-1];
    assign w_b_neg    = w_sel_sgn & w_sel_b[WIDTH-1];
    assign w_div_zero = (w_sel_b == '0);

    // NOTE: state and data registers use non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_grant_vld) begin
                    w_next_state = w_div_zero ? S_RESP : S_ISSUE;
                end
            end
            S_ISSUE: w_next_state = S_WAIT;
            S_WAIT: begin
                if (bus.div_ready_i) begin
                    w_next_state = S_RESP;
                end
            end
            S_RESP: begin
                if (bus.rsp_ready_i) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Accept is combinational; reset gates it so every output reads 0 in reset.
    always_comb begin
        bus.req_ready_o = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            bus.req_ready_o[k] = rst_ni && (r_state == S_IDLE) && w_grant_vld &&
                                 (w_grant_id == ID_W'(k));
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rr_ptr <= '0;
            r_id     <= '0;
            r_mag_a  <= '0;
            r_mag_b  <= '0;
            r_q      <= '0;
            r_r      <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant_vld) begin
                        r_id     <= w_grant_id;
                        r_rr_ptr <= f_wrap(w_grant_id, 1);
                        r_mag_a  <= w_a_neg ? (-w_sel_a) : w_sel_a;
                        r_mag_b  <= w_b_neg ? (-w_sel_b) : w_sel_b;
                        r_neg_q  <= w_a_neg ^ w_b_neg;
                        r_neg_r  <= w_a_neg;
                        if (w_div_zero) begin
                            r_q <= '1;
                            r_r <= w_sel_a;
                        end
                    end
                end
                S_WAIT: begin
                    if (bus.div_ready_i) begin
                        r_q <= r_neg_q ? (-bus.div_quotient_i)  : bus.div_quotient_i;
                        r_r <= r_neg_r ? (-bus.div_remainder_i) : bus.div_remainder_i;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.div_start_o     = (r_state == S_ISSUE);
    assign bus.div_dividend_o  = r_mag_a;
    assign bus.div_divisor_o   = r_mag_b;
    assign bus.rsp_valid_o     = (r_state == S_RESP);
    assign bus.rsp_id_o        = r_id;
    assign bus.rsp_quotient_o  = r_q;
    assign bus.rsp_remainder_o = r_r;
endmodule

// File: tb/tb_div_scheduler.sv
// Bench for div_scheduler: behavioural divider, arithmetic reference model and
// scenario tasks covering arbitration, signed fix-up, bypass and reset.
module tb_div_scheduler;
    localparam int WIDTH   = 32;
    localparam int NUM_REQ = 4;
    localparam int LAT     = WIDTH + 4;
    localparam logic [WIDTH-1:0] MIN_V = {1'b1, {(WIDTH-1){1'b0}}};

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;
    int   n_start;

    div_scheduler_if #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ)) bus ();

    div_scheduler #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural unsigned divider: done flag rises WIDTH+2 cycles after start
    // and stays high until the next start.
    logic [WIDTH-1:0] m_q;
    logic [WIDTH-1:0] m_r;
    logic             m_busy;
    int               m_cnt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_cnt  <= 0;
            m_q    <= '0;
            m_r    <= '0;
        end else if (bus.div_start_o) begin
            m_busy <= 1'b1;
            m_cnt  <= WIDTH + 1;
            m_q    <= (bus.div_divisor_o != 0) ? bus.div_dividend_o / bus.div_divisor_o : '1;
            m_r    <= (bus.div_divisor_o != 0) ? bus.div_dividend_o % bus.div_divisor_o : bus.div_dividend_o;
        end else if (m_busy && m_cnt != 0) begin
            m_cnt <= m_cnt - 1;
        end
    end

    assign bus.div_quotient_i  = m_q;
    assign bus.div_remainder_i = m_r;
    assign bus.div_ready_i     = m_busy && (m_cnt == 0);

    always @(posedge clk) begin
        if (bus.div_start_o) n_start++;
    end

    // Reference arithmetic straight from the operand semantics.
    function automatic void ref_div(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                    input logic sgn, output logic [WIDTH-1:0] q,
                                    output logic [WIDTH-1:0] r);
        longint sa;
        longint sb;
        if (b == 0) begin
            q = '1;
            r = a;
        end else if (!sgn) begin
            q = a / b;
            r = a % b;
        end else begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = WIDTH'(sa / sb);
            r  = WIDTH'(sa % sb);
        end
    endfunction

    task automatic drive_req(input int id, input logic [WIDTH-1:0] a,
                             input logic [WIDTH-1:0] b, input logic sgn);
        bus.req_dividend_i[id*WIDTH +: WIDTH] = a;
        bus.req_divisor_i[id*WIDTH +: WIDTH]  = b;
        bus.req_signed_i[id]                  = sgn;
        bus.req_valid_i[id]                   = 1'b1;
    endtask

    // One full transaction with rsp_ready high; lat = -1 on timeout.
    task automatic run_req(input int id, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic sgn, output logic [WIDTH-1:0] q,
                           output logic [WIDTH-1:0] r, output int rid, output int lat);
        int w;
        q = '0; r = '0; rid = -1; lat = -1;
        @(negedge clk);
        bus.rsp_ready_i = 1'b1;
        drive_req(id, a, b, sgn);
        #1;
        w = 0;
        while (!bus.req_ready_o[id] && w < 200) begin
            @(negedge clk);
            #1;
            w++;
        end
        if (!bus.req_ready_o[id]) begin
            bus.req_valid_i[id] = 1'b0;
            return;
        end
        @(posedge clk);
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            if (c == 1) bus.req_valid_i[id] = 1'b0;
            if (bus.rsp_valid_o) begin
                lat = c;
                q   = bus.rsp_quotient_o;
                r   = bus.rsp_remainder_o;
                rid = int'(bus.rsp_id_o);
                break;
            end
        end
        @(posedge clk);
    endtask

    task automatic check_txn(input string name, input int id, input logic [WIDTH-1:0] a,
                             input logic [WIDTH-1:0] b, input logic sgn);
        logic [WIDTH-1:0] q, r, eq, er;
        int rid, lat, exp_lat;
        run_req(id, a, b, sgn, q, r, rid, lat);
        ref_div(a, b, sgn, eq, er);
        exp_lat = (b == 0) ? 1 : LAT;
        n_vec++;
        if (lat !== exp_lat) begin
            n_err++;
            $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
        end
        n_vec++;
        if (rid !== id) begin
            n_err++;
            $display("FAIL %s id: got %0d expected %0d", name, rid, id);
        end
        n_vec++;
        if (q !== eq || r !== er) begin
            n_err++;
            $display("FAIL %s %h/%h s=%0b: got q=%h r=%h expected q=%h r=%h",
                     name, a, b, sgn, q, r, eq, er);
        end
    endtask

    task automatic check_outputs_zero(input string name);
        n_vec++;
        if (bus.req_ready_o !== '0 || bus.div_start_o !== 1'b0 || bus.rsp_valid_o !== 1'b0 ||
            bus.rsp_id_o !== '0 || bus.rsp_quotient_o !== '0 || bus.rsp_remainder_o !== '0 ||
            bus.div_dividend_o !== '0 || bus.div_divisor_o !== '0) begin
            n_err++;
            $display("FAIL %s: ready=%b start=%b valid=%b id=%0d q=%h r=%h da=%h db=%h expected all 0",
                     name, bus.req_ready_o, bus.div_start_o, bus.rsp_valid_o, bus.rsp_id_o,
                     bus.rsp_quotient_o, bus.rsp_remainder_o, bus.div_dividend_o, bus.div_divisor_o);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.req_valid_i = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n               = 1'b0;
        bus.req_valid_i     = '1;
        bus.req_dividend_i  = '1;
        bus.req_divisor_i   = '1;
        bus.req_signed_i    = '0;
        bus.rsp_ready_i     = 1'b1;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset_state");
        bus.req_valid_i = '0;
        rst_n = 1'b1;
    endtask

    task automatic test_unsigned();
        logic ok_start, ok_valid;
        @(negedge clk);
        bus.rsp_ready_i = 1'b1;
        drive_req(0, 100, 7, 1'b0);
        #1;
        n_vec++;
        if (bus.req_ready_o !== 4'b0001) begin
            n_err++;
            $display("FAIL unsigned_grant: got %b expected 0001", bus.req_ready_o);
        end
        @(posedge clk);
        ok_start = 1'b1;
        ok_valid = 1'b1;
        for (int c = 1; c <= LAT; c++) begin
            @(negedge clk);
            if (c == 1) bus.req_valid_i[0] = 1'b0;
            if (bus.div_start_o !== (c == 1)) begin
                ok_start = 1'b0;
                $display("FAIL unsigned_start cycle %0d: got %b expected %b", c, bus.div_start_o, c == 1);
            end
            if (bus.rsp_valid_o !== (c == LAT)) begin
                ok_valid = 1'b0;
                $display("FAIL unsigned_rsp_valid cycle %0d: got %b expected %b", c, bus.rsp_valid_o, c == LAT);
            end
        end
        n_vec++;
        if (!ok_start) n_err++;
        n_vec++;
        if (!ok_valid) n_err++;
        n_vec++;
        if (bus.rsp_id_o !== 2'd0 || bus.rsp_quotient_o !== 32'd14 || bus.rsp_remainder_o !== 32'd2) begin
            n_err++;
            $display("FAIL unsigned_result: got id=%0d q=%0d r=%0d expected id=0 q=14 r=2",
                     bus.rsp_id_o, bus.rsp_quotient_o, bus.rsp_remainder_o);
        end
        @(posedge clk);
    endtask

    task automatic test_signed();
        check_txn("signed_m7_2", 2, -32'sd7, 32'd2, 1'b1);
        check_txn("signed_min_m1", 2, MIN_V, '1, 1'b1);
        check_txn("signed_7_m2", 3, 32'd7, -32'sd2, 1'b1);
        check_txn("unsigned_big", 1, 32'hFFFF_FFF0, 32'd3, 1'b0);
    endtask

    task automatic test_div_zero();
        int s0;
        s0 = n_start;
        check_txn("divzero_123", 1, 32'd123, 32'd0, 1'b0);
        check_txn("divzero_m5", 0, -32'sd5, 32'd0, 1'b1);
        n_vec++;
        if (n_start !== s0) begin
            n_err++;
            $display("FAIL divzero_no_start: got %0d starts expected %0d", n_start, s0);
        end
    endtask

    task automatic test_round_robin();
        int grants[$];
        int exp_order[5] = '{0, 1, 2, 3, 0};
        logic [WIDTH-1:0] q, r;
        int rid, lat;
        apply_reset();
        @(negedge clk);
        bus.rsp_ready_i = 1'b1;
        for (int k = 0; k < NUM_REQ; k++) drive_req(k, 32'd40 + k, (k == 2) ? 32'd3 : 32'd0, 1'b0);
        for (int c = 0; c < 400 && grants.size() < 5; c++) begin
            #1;
            n_vec++;
            if ($countones(bus.req_ready_o) > 1) begin
                n_err++;
                $display("FAIL rr_onehot: got %b expected at most one bit", bus.req_ready_o);
            end
            for (int k = 0; k < NUM_REQ; k++) if (bus.req_ready_o[k]) grants.push_back(k);
            @(negedge clk);
        end
        @(negedge clk);
        bus.req_valid_i = '0;
        repeat (50) @(negedge clk);
        n_vec++;
        if (grants.size() != 5) begin
            n_err++;
            $display("FAIL rr_count: got %0d grants expected 5", grants.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                n_vec++;
                if (grants[i] !== exp_order[i]) begin
                    n_err++;
                    $display("FAIL rr_order[%0d]: got %0d expected %0d", i, grants[i], exp_order[i]);
                end
            end
        end
        for (int n = 0; n < 2; n++) begin
            run_req(3, 32'd9, 32'd0, 1'b0, q, r, rid, lat);
            n_vec++;
            if (rid !== 3 || lat !== 1) begin
                n_err++;
                $display("FAIL rr_lone3[%0d]: got id=%0d lat=%0d expected id=3 lat=1", n, rid, lat);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [WIDTH-1:0] hq, hr;
        int hid, w;
        logic stable;
        @(negedge clk);
        bus.rsp_ready_i = 1'b0;
        drive_req(0, 32'd1000, 32'd3, 1'b0);
        #1;
        w = 0;
        while (!bus.req_ready_o[0] && w < 100) begin
            @(negedge clk); #1; w++;
        end
        @(posedge clk);
        @(negedge clk);
        bus.req_valid_i[0] = 1'b0;
        drive_req(1, 32'd50, 32'd5, 1'b0);
        w = 0;
        while (!bus.rsp_valid_o && w < 100) begin
            @(negedge clk); w++;
        end
        hq = bus.rsp_quotient_o;
        hr = bus.rsp_remainder_o;
        hid = int'(bus.rsp_id_o);
        n_vec++;
        if (!bus.rsp_valid_o || hq !== 32'd333 || hr !== 32'd1 || hid !== 0) begin
            n_err++;
            $display("FAIL bp_result: got v=%b id=%0d q=%0d r=%0d expected v=1 id=0 q=333 r=1",
                     bus.rsp_valid_o, hid, hq, hr);
        end
        stable = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (!bus.rsp_valid_o || bus.rsp_quotient_o !== hq || bus.rsp_remainder_o !== hr ||
                int'(bus.rsp_id_o) !== hid || bus.req_ready_o !== '0) begin
                stable = 1'b0;
                $display("FAIL bp_hold cycle %0d: got v=%b q=%h r=%h id=%0d ready=%b expected held, ready 0",
                         c, bus.rsp_valid_o, bus.rsp_quotient_o, bus.rsp_remainder_o, bus.rsp_id_o, bus.req_ready_o);
            end
        end
        n_vec++;
        if (!stable) n_err++;
        bus.rsp_ready_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
        n_vec++;
        if (bus.req_ready_o !== 4'b0010) begin
            n_err++;
            $display("FAIL bp_next_grant: got %b expected 0010", bus.req_ready_o);
        end
        @(posedge clk);
        @(negedge clk);
        bus.req_valid_i[1] = 1'b0;
        w = 0;
        while (!bus.rsp_valid_o && w < 100) begin
            @(negedge clk); w++;
        end
        n_vec++;
        if (!bus.rsp_valid_o || bus.rsp_id_o !== 2'd1 || bus.rsp_quotient_o !== 32'd10 ||
            bus.rsp_remainder_o !== 32'd0) begin
            n_err++;
            $display("FAIL bp_second: got v=%b id=%0d q=%0d r=%0d expected v=1 id=1 q=10 r=0",
                     bus.rsp_valid_o, bus.rsp_id_o, bus.rsp_quotient_o, bus.rsp_remainder_o);
        end
        @(posedge clk);
    endtask

    task automatic test_reset_mid_op();
        int w, seen_rsp, seen_start;
        @(negedge clk);
        bus.rsp_ready_i = 1'b1;
        drive_req(2, 32'd1000, 32'd7, 1'b0);
        #1;
        w = 0;
        while (!bus.req_ready_o[2] && w < 100) begin
            @(negedge clk); #1; w++;
        end
        @(posedge clk);
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == 1) bus.req_valid_i[2] = 1'b0;
        end
        drive_req(1, 32'd77, 32'd7, 1'b0);
        rst_n = 1'b0;
        #1;
        check_outputs_zero("reset_mid_op");
        repeat (2) @(negedge clk);
        bus.req_valid_i = '0;
        rst_n = 1'b1;
        seen_rsp = 0;
        seen_start = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (bus.rsp_valid_o) seen_rsp++;
            if (bus.div_start_o) seen_start++;
        end
        n_vec++;
        if (seen_rsp != 0 || seen_start != 0) begin
            n_err++;
            $display("FAIL reset_drop: got %0d rsp / %0d start cycles expected 0", seen_rsp, seen_start);
        end
        check_txn("after_reset", 2, 32'd1000, 32'd7, 1'b0);
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] a, b;
        logic sgn;
        int id;
        for (int n = 0; n < 40; n++) begin
            id  = int'($urandom_range(0, NUM_REQ - 1));
            sgn = 1'($urandom_range(0, 1));
            a   = $urandom;
            b   = $urandom;
            case ($urandom_range(0, 5))
                0: b = '0;
                1: begin a = MIN_V; b = '1; sgn = 1'b1; end
                2: begin a = $urandom_range(0, 200); b = $urandom_range(1, 15); end
                3: b = -WIDTH'($urandom_range(1, 9));
                default: ;
            endcase
            check_txn("random", id, a, b, sgn);
        end
    endtask

    initial begin
        n_vec   = 0;
        n_err   = 0;
        n_start = 0;
        bus.req_valid_i    = '0;
        bus.req_dividend_i = '0;
        bus.req_divisor_i  = '0;
        bus.req_signed_i   = '0;
        bus.rsp_ready_i    = 1'b0;
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_round_robin();
        test_backpressure();
        test_reset_mid_op();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/div_scheduler.md
Name: div_scheduler

Overview:
- Shares one simple_divider instance between NUM_REQ requesters (UART command decoder, ALU op unit, and others) using round-robin arbitration.
- Adds signed division on top of the unsigned divider: operand magnitude conversion on the way in, sign fix-up on the way out.
- Divide-by-zero is resolved locally without occupying the divider.
- Results go out on a single response channel tagged with the requester id, using valid/ready.

Parameters:
- WIDTH, 32, operand/result width; must equal the divider's WIDTH.
- NUM_REQ, 4, number of requesters, minimum 2.
- ID_W, $clog2(NUM_REQ), derived width of the requester id; not to be overridden.

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_ni  in  1  asynchronous active-low reset. The divider instance receives the inverted reset at integration.
- req_valid_i  in  NUM_REQ  per-requester request valid.
- req_ready_o  out  NUM_REQ  per-requester accept; at most one bit high, and only in IDLE.
- req_dividend_i  in  NUM_REQ*WIDTH  packed dividends; requester k occupies [k*WIDTH +: WIDTH].
- req_divisor_i  in  NUM_REQ*WIDTH  packed divisors, same packing.
- req_signed_i  in  NUM_REQ  1 = two's-complement divide, 0 = unsigned.
- div_start_o  out  1  start pulse to the divider.
- div_dividend_o  out  WIDTH  dividend magnitude to the divider.
- div_divisor_o  out  WIDTH  divisor magnitude to the divider.
- div_quotient_i  in  WIDTH  divider quotient.
- div_remainder_i  in  WIDTH  divider remainder.
- div_ready_i  in  1  divider done flag.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  response accept.
- rsp_id_o  out  ID_W  index of the requester that owns the response.
- rsp_quotient_o  out  WIDTH  final quotient.
- rsp_remainder_o  out  WIDTH  final remainder.

Behaviour:

Reset:
- While rst_ni is low: state IDLE, RR pointer 0, all outputs 0, operand/result registers 0.
- Reset takes effect asynchronously, including mid-operation. The in-flight request is dropped and no response is produced.

FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_valid_i bit is high, grant g = the first valid index at or after the RR pointer, wrapping.
  - req_ready_o[g]=1 combinationally this cycle; the handshake completes.
  - Latch the operands, signed flag and id; set the RR pointer to (g+1) mod NUM_REQ.
  - Next state: RESP if the divisor is 0, otherwise ISSUE.
- ISSUE:
  - div_start_o=1 for exactly this one cycle, with the latched magnitudes driven on div_dividend_o/div_divisor_o.
  - Next state: WAIT.
- WAIT:
  - div_start_o=0.
  - When div_ready_i=1, register the sign-fixed results and go to RESP.
  - Holding start low guarantees the divider returns to its idle state before the next ISSUE; the minimum gap is 2 cycles.
- RESP:
  - rsp_valid_o=1; rsp_id_o and the results are held stable.
  - When rsp_ready_i=1, go to IDLE.
  - No new request is accepted until the cycle after the response handshake.

Other handshake and arbitration rules:
- div_ready_i is ignored in IDLE, ISSUE and RESP.
- Requesters must hold their operands stable while req_valid_i is high. Requests are not retracted by the scheduler.

Arithmetic (let a = dividend, b = divisor):
- Unsigned: magnitudes equal the raw operands; results pass through unchanged.
- Signed:
  - The divider receives |a| and |b| (two's-complement negate if the MSB is set).
  - Quotient is negated when sign(a) XOR sign(b).
  - Remainder is negated when sign(a) is set.
  - MIN/-1 yields quotient = MIN, remainder = 0, with no special-casing.
- Divide-by-zero (signed or unsigned):
  - quotient = all ones, remainder = a (raw, unmodified).
  - The divider is never started.

Latency, counting the acceptance cycle as 0:
- Normal request: ISSUE in cycle 1; rsp_valid_o rises in cycle WIDTH+4 (cycle 36 for WIDTH=32).
- Divide-by-zero: rsp_valid_o rises in cycle 1.

Test Plan:
- Unsigned path: requester 0 sends 100/7 unsigned. Required: req_ready_o=0001 in cycle 0, div_start_o high only in cycle 1, and rsp_valid_o in cycle 36 with id 0, q=14, r=2.
- Signed path: requester 2 sends -7/2 signed. Required: q=0xFFFFFFFD, r=0xFFFFFFFF. Also 0x80000000 / 0xFFFFFFFF signed gives q=0x80000000, r=0.
- Divide-by-zero bypass: requester 1 sends 123/0. Required: div_start_o never asserted, and rsp_valid_o in cycle 1 with q=0xFFFFFFFF, r=123. A signed -5/0 gives r=0xFFFFFFFB.
- Round-robin fairness: all four req_valid_i held high with rsp_ready_i=1. Required grant order 0,1,2,3,0. A lone requester 3 after a grant to 3 is granted again.
- Response backpressure: hold rsp_ready_i=0 for 10 cycles in RESP. Required: rsp_valid_o and the data are stable, and no req_ready_o is asserted. After release, the next grant comes in the following cycle.
- Reset mid-operation: assert rst_ni=0 during WAIT (cycle 20). Required: all outputs are 0 immediately and no response is produced. After release, a new request completes normally with correct results.
